alu_writeback_unit: RTL and testbench
=====================================

Name: alu_writeback_unit

Overview:
- Receiving end of the ALU execute-stage output latch: takes result, rename-register write enable and reorder-buffer write enable, plus tags carried alongside.
- Buffers completions in a small FIFO until the shared writeback port grants a slot.
- On grant, writes the rename register file (RRF) and marks the reorder buffer (ROB) entry finished.
- Asserts back-pressure toward issue before the buffer can overflow.

Parameters:
- DATA_LEN, 32, result width.
- RRF_SEL, 6, RRF tag width.
- ROB_SEL, 6, ROB tag width.
- DEPTH, 4, FIFO entries; power of two, minimum 4.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset.
- ex_result_i  in  DATA_LEN  latched ALU result.
- ex_rob_we_i  in  1  completion valid; pushes one entry.
- ex_rrf_we_i  in  1  entry also writes the RRF.
- ex_rrf_tag_i  in  RRF_SEL  destination RRF tag.
- ex_rob_tag_i  in  ROB_SEL  ROB entry to finish.
- wb_grant_i  in  1  shared writeback port is granted this cycle.
- kill_i  in  1  pipeline flush.
- rrf_we_o  out  1  RRF write strobe.
- rrf_waddr_o  out  RRF_SEL  RRF write address.
- rrf_wdata_o  out  DATA_LEN  RRF write data.
- rob_finish_we_o  out  1  ROB finish strobe.
- rob_finish_addr_o  out  ROB_SEL  ROB entry being finished.
- wb_req_o  out  1  entry waiting; requests the port.
- stall_o  out  1  back-pressure to issue.
- overflow_o  out  1  sticky error flag.

Behaviour:
- Reset (reset_i==0 at posedge):
  - Pointers and count cleared to 0; overflow_o cleared.
  - All outputs read 0 while empty.
- Entry format: {rrf_we, rrf_tag, rob_tag, data}.
- Push: ex_rob_we_i==1, kill_i==0 and (count<DEPTH or pop this cycle). Inputs are captured at the posedge.
- Pop: count>0 and wb_grant_i==1. Head entry is written out combinationally in the same cycle:
  - rob_finish_we_o=1, rob_finish_addr_o=head.rob_tag.
  - rrf_we_o=head.rrf_we, rrf_waddr_o=head.rrf_tag, rrf_wdata_o=head.data.
- No pop: all strobes are 0. Address and data outputs are 0.
- wb_req_o = (count>0).
- Latency: without fastpath, input at edge t is visible at the earliest in cycle t+1.
- Grant while empty: ignored, no output.
- Simultaneous push and pop:
  - Allowed at any count, including full (pop frees the slot first).
  - Count unchanged; order preserved.
- Push when full with no pop: entry dropped, count unchanged, overflow_o set to 1 until reset.
- Entry with ex_rrf_we_i==0: occupies a slot; on pop it finishes the ROB only (rrf_we_o=0).
- stall_o = (count >= DEPTH-2), combinational from count. Two slots of headroom absorb the two completions already in flight through the execute stage and its latch.
- kill_i:
  - At the next edge, count and both pointers go to 0.
  - A same-cycle push is discarded.
  - A same-cycle pop still drives its strobes: the arbiter owns the consequence. The entry is not re-presented.
  - overflow_o is not cleared.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- reset_i has priority over kill_i, push and pop.

Optional Feature:
- WB_FASTPATH_EN defined: when count==0, ex_rob_we_i==1, wb_grant_i==1 and kill_i==0, the input drives the RRF/ROB outputs in the same cycle, with zero latency. No entry is pushed. wb_req_o=1 that cycle.
- Undefined: every completion passes through the FIFO, giving minimum one-cycle latency.
- Fastpath makes outputs combinational from ex_* inputs; timing is reviewed accordingly.

Decomposition:
- Consts.vh: DATA_LEN, RRF_SEL, ROB_SEL, and entry field offsets/width (WB_ENTRY_LEN = 1+RRF_SEL+ROB_SEL+DATA_LEN).
- Sub-module wb_fifo:
  - Generic synchronous FIFO: WIDTH, DEPTH, push/pop/flush, count, full/empty.
  - Drop-on-full plus overflow pulse.
- Top level handles:
  - Entry packing.
  - Grant gating.
  - Stall threshold.
  - Fastpath mux.
  - Sticky overflow.

Test Plan:
- Reset low for 2 cycles, then push 0xDEADBEEF (rrf 5, rob 9, rrf_we=1) with grant low → wb_req_o=1; all strobes 0.
  - Then grant=1 → rrf_we_o=1, rrf_waddr_o=5, rrf_wdata_o=0xDEADBEEF, rob_finish_addr_o=9.
  - Next cycle wb_req_o=0.
- Push 4 entries with grant held low → stall_o rises when count reaches 2.
  - 5th push sets overflow_o=1 and count stays 4.
  - Then 4 grants drain entries in FIFO order with tags 0,1,2,3.
- DEPTH=4 full, push and grant in the same cycle → oldest pops, new entry accepted, overflow_o stays 0.
- Push with ex_rrf_we_i=0 (rob 3), then grant → rob_finish_we_o=1, addr 3, rrf_we_o=0.
- 3 entries queued, kill_i=1 with a simultaneous push → next cycle count=0, wb_req_o=0, stall_o=0.
  - Subsequent grant produces no strobe.
- With WB_FASTPATH_EN, empty FIFO, push (rob 7, data 0x1) with grant=1 → same-cycle rob_finish_we_o=1, addr 7.
  - Next cycle wb_req_o=0.
  - Without the macro, the strobe appears one cycle later.

Source files
------------

// File: rtl/alu_writeback_unit_pkg.sv
// Shared widths and entry layout helpers for the ALU writeback unit.
package alu_writeback_unit_pkg;

  localparam int WB_DATA_LEN = 32;
  localparam int WB_RRF_SEL  = 6;
  localparam int WB_ROB_SEL  = 6;
  localparam int WB_DEPTH    = 4;

  // Entry layout, MSB first: {rrf_we, rrf_tag, rob_tag, data}
  function automatic int wb_entry_len(input int data_len, input int rrf_sel, input int rob_sel);
    return 1 + rrf_sel + rob_sel + data_len;
  endfunction

  function automatic int wb_rob_lsb(input int data_len);
    return data_len;
  endfunction

  function automatic int wb_rrf_lsb(input int data_len, input int rob_sel);
    return data_len + rob_sel;
  endfunction

endpackage

// File: rtl/alu_writeback_unit_wb_fifo.sv
// Generic synchronous FIFO with flush, drop-on-full and a one-cycle overflow pulse.
module alu_writeback_unit_wb_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop & ~empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push_ok  = push & ~flush & (~full | pop_ok);
  assign overflow = push & ~flush & full & ~pop_ok;
  assign rdata    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/alu_writeback_unit.sv
// Buffers ALU completions and writes them to the RRF/ROB when the writeback port is granted.
// Optional zero-latency bypass when built with WB_FASTPATH_EN.
module alu_writeback_unit
  import alu_writeback_unit_pkg::*;
#(
  parameter int DATA_LEN = WB_DATA_LEN,
  parameter int RRF_SEL  = WB_RRF_SEL,
  parameter int ROB_SEL  = WB_ROB_SEL,
  parameter int DEPTH    = WB_DEPTH
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [DATA_LEN-1:0] ex_result_i,
  input  logic                ex_rob_we_i,
  input  logic                ex_rrf_we_i,
  input  logic [RRF_SEL-1:0]  ex_rrf_tag_i,
  input  logic [ROB_SEL-1:0]  ex_rob_tag_i,
  input  logic                wb_grant_i,
  input  logic                kill_i,
  output logic                rrf_we_o,
  output logic [RRF_SEL-1:0]  rrf_waddr_o,
  output logic [DATA_LEN-1:0] rrf_wdata_o,
  output logic                rob_finish_we_o,
  output logic [ROB_SEL-1:0]  rob_finish_addr_o,
  output logic                wb_req_o,
  output logic                stall_o,
  output logic                overflow_o
);

  localparam int ENTRY_LEN = wb_entry_len(DATA_LEN, RRF_SEL, ROB_SEL);
  localparam int ROB_LSB   = wb_rob_lsb(DATA_LEN);
  localparam int RRF_LSB   = wb_rrf_lsb(DATA_LEN, ROB_SEL);
  localparam int CW        = $clog2(DEPTH) + 1;

  logic [ENTRY_LEN-1:0] in_entry;
  logic [ENTRY_LEN-1:0] head;
  logic [CW-1:0]        count;
  logic                 empty;
  logic                 drop;
  logic                 fast;
  logic                 push;
  logic                 pop_ok;

`ifdef WB_FASTPATH_EN
  assign fast = empty & ex_rob_we_i & wb_grant_i & ~kill_i;
`else
  assign fast = 1'b0;
`endif

  assign in_entry = {ex_rrf_we_i, ex_rrf_tag_i, ex_rob_tag_i, ex_result_i};
  assign push     = ex_rob_we_i & ~kill_i & ~fast;
  assign pop_ok   = wb_grant_i & ~empty;

  alu_writeback_unit_wb_fifo #(
    .WIDTH (ENTRY_LEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .push     (push),
    .pop      (wb_grant_i),
    .flush    (kill_i),
    .wdata    (in_entry),
    .rdata    (head),
    .count    (count),
    .empty    (empty),
    .overflow (drop)
  );

  always_comb begin
    rrf_we_o          = 1'b0;
    rrf_waddr_o       = '0;
    rrf_wdata_o       = '0;
    rob_finish_we_o   = 1'b0;
    rob_finish_addr_o = '0;
    if (pop_ok) begin
      rrf_we_o          = head[ENTRY_LEN-1];
      rrf_waddr_o       = head[RRF_LSB +: RRF_SEL];
      rrf_wdata_o       = head[DATA_LEN-1:0];
      rob_finish_we_o   = 1'b1;
      rob_finish_addr_o = head[ROB_LSB +: ROB_SEL];
    end else if (fast) begin
      rrf_we_o          = ex_rrf_we_i;
      rrf_waddr_o       = ex_rrf_tag_i;
      rrf_wdata_o       = ex_result_i;
      rob_finish_we_o   = 1'b1;
      rob_finish_addr_o = ex_rob_tag_i;
    end
  end

  assign wb_req_o = ~empty | fast;
  // Two slots of headroom cover completions already in flight through execute and its latch.
  assign stall_o  = (count >= CW'(DEPTH - 2));

  always_ff @(posedge clk_i) begin
    if (!reset_i)  overflow_o <= 1'b0;
    else if (drop) overflow_o <= 1'b1;
  end

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed self-checking bench for alu_writeback_unit (default DEPTH=4).
module tb_alu_writeback_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] ex_result_i;
  logic        ex_rob_we_i;
  logic        ex_rrf_we_i;
  logic [5:0]  ex_rrf_tag_i;
  logic [5:0]  ex_rob_tag_i;
  logic        wb_grant_i;
  logic        kill_i;
  logic        rrf_we_o;
  logic [5:0]  rrf_waddr_o;
  logic [31:0] rrf_wdata_o;
  logic        rob_finish_we_o;
  logic [5:0]  rob_finish_addr_o;
  logic        wb_req_o;
  logic        stall_o;
  logic        overflow_o;

  int total = 0;
  int fails = 0;

  alu_writeback_unit dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .ex_result_i       (ex_result_i),
    .ex_rob_we_i       (ex_rob_we_i),
    .ex_rrf_we_i       (ex_rrf_we_i),
    .ex_rrf_tag_i      (ex_rrf_tag_i),
    .ex_rob_tag_i      (ex_rob_tag_i),
    .wb_grant_i        (wb_grant_i),
    .kill_i            (kill_i),
    .rrf_we_o          (rrf_we_o),
    .rrf_waddr_o       (rrf_waddr_o),
    .rrf_wdata_o       (rrf_wdata_o),
    .rob_finish_we_o   (rob_finish_we_o),
    .rob_finish_addr_o (rob_finish_addr_o),
    .wb_req_o          (wb_req_o),
    .stall_o           (stall_o),
    .overflow_o        (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic rrf_we, input logic [5:0] rrf_tag,
                       input logic [5:0] rob_tag, input logic [31:0] data);
    ex_rob_we_i  = we;
    ex_rrf_we_i  = rrf_we;
    ex_rrf_tag_i = rrf_tag;
    ex_rob_tag_i = rob_tag;
    ex_result_i  = data;
  endtask

  initial begin
    reset_i    = 1'b0;
    wb_grant_i = 1'b0;
    kill_i     = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 6'd0, 32'h0);
    tick();
    tick();
    chk("rst_req", wb_req_o, 0);
    chk("rst_rob_we", rob_finish_we_o, 0);
    chk("rst_rrf_we", rrf_we_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_ovf", overflow_o, 0);
    reset_i = 1'b1;

    // single entry, one-cycle latency
    drive(1'b1, 1'b1, 6'd5, 6'd9, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 6'd0, 6'd0, 32'h0);
    #1;
    chk("t1_req", wb_req_o, 1);
    chk("t1_nogrant_rob_we", rob_finish_we_o, 0);
    chk("t1_nogrant_rrf_we", rrf_we_o, 0);
    chk("t1_nogrant_data", rrf_wdata_o, 0);
    wb_grant_i = 1'b1;
    #1;
    chk("t1_rrf_we", rrf_we_o, 1);
    chk("t1_waddr", rrf_waddr_o, 5);
    chk("t1_wdata", rrf_wdata_o, 32'hDEADBEEF);
    chk("t1_rob_we", rob_finish_we_o, 1);
    chk("t1_rob_addr", rob_finish_addr_o, 9);
    tick();
    chk("t1_req_after", wb_req_o, 0);
    chk("empty_grant_rob_we", rob_finish_we_o, 0);
    chk("empty_grant_addr", rob_finish_addr_o, 0);
    wb_grant_i = 1'b0;

    // fill, stall threshold, overflow on 5th push
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 6'(i + 1), 6'(i), 32'h100 + 32'(i));
      tick();
      chk($sformatf("fill_stall_%0d", i + 1), stall_o, (i + 1 >= 2) ? 1 : 0);
    end
    chk("full_ovf_before", overflow_o, 0);
    drive(1'b1, 1'b1, 6'd40, 6'd4, 32'h999);
    tick();
    drive(1'b0, 1'b0, 6'd0, 6'd0, 32'h0);
    #1;
    chk("ovf_set", overflow_o, 1);
    chk("ovf_stall", stall_o, 1);
    wb_grant_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_rob_%0d", i), rob_finish_addr_o, i);
      chk($sformatf("drain_data_%0d", i), rrf_wdata_o, 32'h100 + i);
      chk($sformatf("drain_rrf_%0d", i), rrf_waddr_o, i + 1);
      tick();
    end
    chk("drain_req", wb_req_o, 0);
    chk("drain_rob_we", rob_finish_we_o, 0);
    chk("ovf_sticky", overflow_o, 1);
    wb_grant_i = 1'b0;

    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    chk("ovf_cleared", overflow_o, 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 6'd1, 6'(10 + i), 32'h200 + 32'(i));
      tick();
    end
    drive(1'b1, 1'b1, 6'd1, 6'd14, 32'h204);
    wb_grant_i = 1'b1;
    #1;
    chk("pp_head", rob_finish_addr_o, 10);
    tick();
    drive(1'b0, 1'b0, 6'd0, 6'd0, 32'h0);
    #1;
    chk("pp_ovf", overflow_o, 0);
    chk("pp_stall", stall_o, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("pp_drain_%0d", i), rob_finish_addr_o, 11 + i);
      tick();
    end
    chk("pp_req", wb_req_o, 0);
    wb_grant_i = 1'b0;

    // ROB-only entry
    drive(1'b1, 1'b0, 6'd7, 6'd3, 32'h55);
    tick();
    drive(1'b0, 1'b0, 6'd0, 6'd0, 32'h0);
    wb_grant_i = 1'b1;
    #1;
    chk("robonly_rob_we", rob_finish_we_o, 1);
    chk("robonly_addr", rob_finish_addr_o, 3);
    chk("robonly_rrf_we", rrf_we_o, 0);
    tick();
    wb_grant_i = 1'b0;

    // kill with simultaneous push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 6'd2, 6'(20 + i), 32'h300 + 32'(i));
      tick();
    end
    chk("prekill_stall", stall_o, 1);
    drive(1'b1, 1'b1, 6'd2, 6'd23, 32'h303);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 6'd0, 32'h0);
    #1;
    chk("kill_req", wb_req_o, 0);
    chk("kill_stall", stall_o, 0);
    wb_grant_i = 1'b1;
    #1;
    chk("kill_grant_rob_we", rob_finish_we_o, 0);
    chk("kill_ovf", overflow_o, 0);
    tick();
    wb_grant_i = 1'b0;

    // fastpath vs. buffered latency
    drive(1'b1, 1'b1, 6'd8, 6'd7, 32'h1);
    wb_grant_i = 1'b1;
    #1;
`ifdef WB_FASTPATH_EN
    chk("fp_same_rob_we", rob_finish_we_o, 1);
    chk("fp_same_addr", rob_finish_addr_o, 7);
    chk("fp_same_req", wb_req_o, 1);
`else
    chk("nofp_same_rob_we", rob_finish_we_o, 0);
    chk("nofp_same_req", wb_req_o, 0);
`endif
    tick();
    drive(1'b0, 1'b0, 6'd0, 6'd0, 32'h0);
    #1;
`ifdef WB_FASTPATH_EN
    chk("fp_next_rob_we", rob_finish_we_o, 0);
    chk("fp_next_req", wb_req_o, 0);
`else
    chk("nofp_next_rob_we", rob_finish_we_o, 1);
    chk("nofp_next_addr", rob_finish_addr_o, 7);
    chk("nofp_next_data", rrf_wdata_o, 1);
`endif
    tick();
    wb_grant_i = 1'b0;
    #1;
    chk("fp_end_req", wb_req_o, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
